// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: mode select values,
// FSM states and the pattern loaded when a mode is entered.
package led_seq_pkg;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SWEEP = 2'b01;
    localparam logic [1:0] MODE_COUNT = 2'b10;
    localparam logic [1:0] MODE_FILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_SWEEP_UP,
        ST_SWEEP_DN,
        ST_COUNT,
        ST_FILL,
        ST_EMPTY
    } seq_state_e;

    localparam int unsigned START_SWEEP = 1;
    localparam int unsigned START_COUNT = 0;
    localparam int unsigned START_FILL  = 1;

    // FSM state a given mode starts in when it is first selected.
    function automatic seq_state_e start_state(input logic [1:0] m);
        case (m)
            MODE_SWEEP: return ST_SWEEP_UP;
            MODE_COUNT: return ST_COUNT;
            MODE_FILL:  return ST_FILL;
            default:    return ST_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter and brightness gate; an all-ones duty forces
// the gate permanently on so full brightness has no dark slot.
module led_pwm #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    output logic                gate
);

    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

    assign gate = (&duty) || (pwm_cnt < duty);

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: advances an 8-bit pattern on each step pulse in
// one of four modes and drives the LEDs through a PWM brightness gate.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step_pulse,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] duty,
    output logic [WIDTH-1:0]    led,
    output logic                wrap_pulse
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] TOP_BIT  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LOW_BIT  = WIDTH'(1);

    seq_state_e       state, state_nxt;
    logic [WIDTH-1:0] pat, pat_nxt;
    logic [1:0]       cur_mode, mode_nxt;
    logic             wrap_nxt;
    logic             gate;

    logic [WIDTH-1:0] shl, shr, fill_in, empty_in, inc;
    assign shl      = {pat[WIDTH-2:0], 1'b0};
    assign shr      = {1'b0, pat[WIDTH-1:1]};
    assign fill_in  = {pat[WIDTH-2:0], 1'b1};
    assign empty_in = {pat[WIDTH-2:0], 1'b0};
    assign inc      = pat + WIDTH'(1);

    led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (duty),
        .gate  (gate)
    );

    always_comb begin
        state_nxt = state;
        pat_nxt   = pat;
        mode_nxt  = cur_mode;
        wrap_nxt  = 1'b0;
        if (step_pulse) begin
            if (mode != cur_mode) begin
                // A mode change only loads the start pattern; it never wraps.
                mode_nxt  = mode;
                state_nxt = start_state(mode);
                case (mode)
                    MODE_SWEEP: pat_nxt = WIDTH'(START_SWEEP);
                    MODE_COUNT: pat_nxt = WIDTH'(START_COUNT);
                    MODE_FILL:  pat_nxt = WIDTH'(START_FILL);
                    default:    pat_nxt = pat;
                endcase
            end else begin
                case (state)
                    ST_SWEEP_UP: begin
                        pat_nxt = shl;
                        if (shl == TOP_BIT) state_nxt = ST_SWEEP_DN;
                    end
                    ST_SWEEP_DN: begin
                        pat_nxt = shr;
                        if (shr == LOW_BIT) begin
                            state_nxt = ST_SWEEP_UP;
                            wrap_nxt  = 1'b1;
                        end
                    end
                    ST_COUNT: begin
                        pat_nxt  = inc;
                        wrap_nxt = (pat == ALL_ONES);
                    end
                    ST_FILL: begin
                        pat_nxt = fill_in;
                        if (fill_in == ALL_ONES) state_nxt = ST_EMPTY;
                    end
                    ST_EMPTY: begin
                        pat_nxt = empty_in;
                        if (empty_in == '0) begin
                            state_nxt = ST_FILL;
                            wrap_nxt  = 1'b1;
                        end
                    end
                    default: pat_nxt = pat;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HOLD;
            pat        <= '0;
            cur_mode   <= MODE_HOLD;
            wrap_pulse <= 1'b0;
            led        <= '0;
        end else begin
            state      <= state_nxt;
            pat        <= pat_nxt;
            cur_mode   <= mode_nxt;
            wrap_pulse <= wrap_nxt;
            led        <= pat & {WIDTH{gate}};
        end
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq: a behavioural pattern model pushes
// expected pattern/wrap per step; the DUT outputs are popped and compared.
module tb_led_pattern_seq;

    logic       clk;
    logic       rst_n;
    logic       step_pulse;
    logic [1:0] mode;
    logic [3:0] duty;
    logic [7:0] led;
    logic       wrap_pulse;

    led_pattern_seq #(.WIDTH(8), .PWM_BITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_pulse (step_pulse),
        .mode       (mode),
        .duty       (duty),
        .led        (led),
        .wrap_pulse (wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pat;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   wraps = 0;

    // model state: 0 hold, 1 sweep up, 2 sweep down, 3 count, 4 fill, 5 empty
    int         m_st   = 0;
    logic [7:0] m_pat  = 8'h00;
    logic [1:0] m_mode = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [1:0] m, output exp_t e);
        e.wrap = 1'b0;
        if (m != m_mode) begin
            m_mode = m;
            case (m)
                2'b01:   begin m_pat = 8'h01; m_st = 1; end
                2'b10:   begin m_pat = 8'h00; m_st = 3; end
                2'b11:   begin m_pat = 8'h01; m_st = 4; end
                default: m_st = 0;
            endcase
        end else begin
            case (m_st)
                1: begin m_pat = m_pat << 1; if (m_pat == 8'h80) m_st = 2; end
                2: begin
                    m_pat = m_pat >> 1;
                    if (m_pat == 8'h01) begin m_st = 1; e.wrap = 1'b1; end
                end
                3: begin e.wrap = (m_pat == 8'hFF); m_pat = m_pat + 8'h01; end
                4: begin m_pat = {m_pat[6:0], 1'b1}; if (m_pat == 8'hFF) m_st = 5; end
                5: begin
                    m_pat = {m_pat[6:0], 1'b0};
                    if (m_pat == 8'h00) begin m_st = 4; e.wrap = 1'b1; end
                end
                default: ;
            endcase
        end
        e.pat = m_pat;
    endtask

    task automatic do_step(input logic [1:0] m, input int gap);
        exp_t e;
        @(negedge clk);
        mode       = m;
        step_pulse = 1'b1;
        model_step(m, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        step_pulse = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("wrap", wrap_pulse, e.wrap);
            wraps += int'(wrap_pulse);
            @(posedge clk);
            #1;
            chk("wrap_one_cycle", wrap_pulse, 0);
            chk("led", led, e.pat);
        end
        repeat (gap) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int   hi;
        exp_t e;
        exp_t prev;
        rst_n      = 1'b0;
        step_pulse = 1'b0;
        mode       = 2'b00;
        duty       = 4'hF;
        #1;
        chk("reset_led", led, 0);
        chk("reset_wrap", wrap_pulse, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_led", led, 0);

        // SWEEP: load 0x01, then 0x02..0x80..0x01 with one wrap at the end
        do_step(2'b01, 7);
        chk("sweep_load", led, 8'h01);
        wraps = 0;
        for (int i = 0; i < 14; i++) do_step(2'b01, 7);
        chk("sweep_end", led, 8'h01);
        chk("sweep_wraps", wraps, 1);

        // mode change without a step has no effect
        @(negedge clk);
        mode = 2'b10;
        repeat (5) @(posedge clk);
        #1;
        chk("mode_no_step", led, 8'h01);

        // COUNT: mode change loads 0x00, then 256 steps with one wrap
        do_step(2'b10, 0);
        chk("count_load", led, 8'h00);
        wraps = 0;
        for (int i = 0; i < 256; i++) do_step(2'b10, 0);
        chk("count_end", led, 8'h00);
        chk("count_wraps", wraps, 1);

        // FILL/EMPTY: load 0x01, fill to 0xFF, empty to 0x00, then 0x01
        do_step(2'b11, 0);
        wraps = 0;
        for (int i = 0; i < 7; i++) do_step(2'b11, 0);
        chk("fill_full", led, 8'hFF);
        for (int i = 0; i < 8; i++) do_step(2'b11, 0);
        chk("empty_done", led, 8'h00);
        chk("fill_wraps", wraps, 1);
        do_step(2'b11, 0);
        chk("fill_restart", led, 8'h01);

        // HOLD freezes the pattern
        do_step(2'b00, 0);
        for (int i = 0; i < 3; i++) do_step(2'b00, 2);
        chk("hold_frozen", led, 8'h01);

        // PWM brightness on pattern 0x01
        do_step(2'b01, 0);
        @(negedge clk);
        duty = 4'd4;
        repeat (2) @(posedge clk);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            hi += int'(led[0]);
        end
        chk("pwm_duty4_hi", hi, 4);
        @(negedge clk);
        duty = 4'd0;
        repeat (2) @(posedge clk);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            hi += int'(led != 8'h00);
        end
        chk("pwm_duty0_hi", hi, 0);
        @(negedge clk);
        duty = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("pwm_full", led, 8'h01);

        // back-to-back pulses from 0x01 in sweep
        @(negedge clk);
        mode       = 2'b01;
        step_pulse = 1'b1;
        for (int k = 0; k < 3; k++) begin
            model_step(2'b01, e);
            sb.push_back(e);
        end
        prev.pat  = 8'h01;
        prev.wrap = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) step_pulse = 1'b0;
            chk("burst_led", led, prev.pat);
            if (sb.size() == 0) chk("sb_empty", 1, 0);
            else begin
                prev = sb.pop_front();
                chk("burst_wrap", wrap_pulse, prev.wrap);
            end
        end
        @(posedge clk);
        #1;
        chk("burst_final_model", led, prev.pat);
        chk("burst_final", led, 8'h08);

        // asynchronous reset mid-pattern, between clock edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_led", led, 0);
        chk("async_rst_wrap", wrap_pulse, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_led", led, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
